// File: rtl/cnt_pattern_gen.sv
// cnt_pattern_gen: counter pattern generator used as a stimulus/trigger source
// for capture logic. It provides:
//   - a wrap-detecting capture counter with start/end flags
//   - a programmable-period phase counter with ref pulse, window and toggle
//   - NUM_CH split up/down channel counters gated by the toggle
// All outputs are registered.

// One channel: two independent CH_WIDTH/2 halves moving in opposite
// directions by a fixed per-channel offset. There is no carry between halves.
module cnt_pattern_ch #(
  parameter int CH_WIDTH = 64,
  parameter int OFFSET   = 1
) (
  input  logic                osc_ext,
  input  logic                reset,
  input  logic                clr,
  input  logic                adv,
  input  logic                dir,
  output logic [CH_WIDTH-1:0] ch_cnt
);
  localparam int            HW  = CH_WIDTH / 2;
  localparam logic [HW-1:0] OFS = HW'(OFFSET);

  logic [HW-1:0] upper, lower;

  // Halves reload to the offset on any reset; otherwise step opposite ways on advance.
  always_ff @(posedge osc_ext or posedge reset) begin
    if (reset) begin
      upper <= OFS;
      lower <= OFS;
    end else if (clr) begin
      upper <= OFS;
      lower <= OFS;
    end else if (adv) begin
      if (dir) begin
        upper <= upper + OFS;
        lower <= lower - OFS;
      end else begin
        upper <= upper - OFS;
        lower <= lower + OFS;
      end
    end
  end

  assign ch_cnt = {upper, lower};
endmodule

module cnt_pattern_gen #(
  parameter int CNT_WIDTH = 16,
  parameter int PERIOD    = 276,
  parameter int WIN_START = 100,
  parameter int WIN_END   = 150,
  parameter int NUM_CH    = 27,
  parameter int CH_WIDTH  = 64,
  parameter int PH_WIDTH  = $clog2(PERIOD + 1)
) (
  input  logic                         osc_ext,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         counter_reset,
  input  logic                         dir,
  input  logic [NUM_CH-1:0]            ch_en,
  output logic [CNT_WIDTH-1:0]         cnt_out,
  output logic [CNT_WIDTH-1:0]         cnt_dly_out,
  output logic                         start_flag,
  output logic                         end_flag,
  output logic                         ref_pulse,
  output logic                         window,
  output logic                         toggle,
  output logic [NUM_CH*CH_WIDTH-1:0]   ch_cnt
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAXM1 = {{(CNT_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [PH_WIDTH-1:0]  PH_MAX    = PH_WIDTH'(PERIOD);
  localparam logic [PH_WIDTH-1:0]  PH_WS     = PH_WIDTH'(WIN_START);
  localparam logic [PH_WIDTH-1:0]  PH_WE     = PH_WIDTH'(WIN_END);

  logic                             step;
  logic [PH_WIDTH-1:0]              phase;
  logic [NUM_CH-1:0][CH_WIDTH-1:0]  ch_q;

  // An edge advances only when enabled and not being cleared.
  assign step = enable & ~counter_reset;

  // Capture counter and its one-step-delayed copy.
  always_ff @(posedge osc_ext or posedge reset) begin
    if (reset) begin
      cnt_out     <= '0;
      cnt_dly_out <= '0;
    end else if (counter_reset) begin
      cnt_out     <= '0;
      cnt_dly_out <= '0;
    end else if (step) begin
      cnt_out     <= cnt_out + 1'b1;
      cnt_dly_out <= cnt_out;
    end
  end

  // Wrap/terminal flags. They are qualified by the advancing edge, so a counter
  // frozen on a wrap value fires once, on its next advance, and never repeats.
  always_ff @(posedge osc_ext or posedge reset) begin
    if (reset) begin
      start_flag <= 1'b0;
      end_flag   <= 1'b0;
    end else if (counter_reset) begin
      start_flag <= 1'b0;
      end_flag   <= 1'b0;
    end else begin
      start_flag <= step && (cnt_out == '0) && (cnt_dly_out == CNT_MAX);
      end_flag   <= step && (cnt_out == CNT_MAX) && (cnt_dly_out == CNT_MAXM1);
    end
  end

  // Phase counter 0..PERIOD with a reference pulse on each wrap.
  always_ff @(posedge osc_ext or posedge reset) begin
    if (reset) begin
      phase     <= '0;
      ref_pulse <= 1'b0;
    end else if (counter_reset) begin
      phase     <= '0;
      ref_pulse <= 1'b0;
    end else begin
      ref_pulse <= step && (phase == PH_MAX);
      if (step) phase <= (phase == PH_MAX) ? '0 : phase + 1'b1;
    end
  end

  // Window opens at WIN_START and closes at WIN_END. It is evaluated on steps only.
  always_ff @(posedge osc_ext or posedge reset) begin
    if (reset)                        window <= 1'b0;
    else if (counter_reset)           window <= 1'b0;
    else if (step && phase == PH_WS)  window <= 1'b1;
    else if (step && phase == PH_WE)  window <= 1'b0;
  end

  // Toggle flips once per reference pulse and gates the channel advance.
  always_ff @(posedge osc_ext or posedge reset) begin
    if (reset)              toggle <= 1'b0;
    else if (counter_reset) toggle <= 1'b0;
    else if (ref_pulse)     toggle <= ~toggle;
  end

  // Channel array. Channel k uses offset k+1.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    cnt_pattern_ch #(
      .CH_WIDTH (CH_WIDTH),
      .OFFSET   (k + 1)
    ) u_ch (
      .osc_ext (osc_ext),
      .reset   (reset),
      .clr     (counter_reset),
      .adv     (step & toggle & ch_en[k]),
      .dir     (dir),
      .ch_cnt  (ch_q[k])
    );
  end

  assign ch_cnt = ch_q;
endmodule
